// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing controller: gated 500 Hz / 4 Hz buzzer, auto-stop, stop and snooze.
// Optional snooze feature enabled by defining RING_SNOOZE_EN.
module alarm_ring_ctrl #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk_in_50M,
  input  logic       rst_n,
  input  logic       tone_500Hz,
  input  logic       gate_4Hz,
  input  logic       tick_1Hz,
  input  logic       alarm_en,
  input  logic       alarm_match,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer_out,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_cnt
);

`ifdef RING_SNOOZE_EN
  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RINGING
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [8:0] sec_cnt_q, sec_cnt_d;

  logic       tick_q, match_q, stop_q;
  logic       sec_p_q, match_p_q, stop_p_q;
  logic       buzzer_q, ringing_q;

`ifdef RING_SNOOZE_EN
  logic       snz_q, snz_p_q;
  logic [2:0] snz_cnt_q, snz_cnt_d;
  logic       snoozing_q;
`else
  logic       unused_snz;
  assign unused_snz = snooze_btn
                    | (SNOOZE_SECONDS == 0)
                    | (MAX_SNOOZE == 0);
`endif

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
`ifdef RING_SNOOZE_EN
    snz_cnt_d = snz_cnt_q;
`endif
    if (!alarm_en) begin
      state_d = IDLE;
    end else if (stop_p_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match_p_q) state_d = RINGING;
        end
        RINGING: begin
`ifdef RING_SNOOZE_EN
          if (snz_p_q && (snz_cnt_q < 3'(MAX_SNOOZE))) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + 3'd1;
          end else
`endif
          if (sec_p_q) begin
            if (sec_cnt_q == 9'(RING_SECONDS - 1))
              state_d = IDLE;
            else
              sec_cnt_d = sec_cnt_q + 9'd1;
          end
        end
`ifdef RING_SNOOZE_EN
        SNOOZE: begin
          if (sec_p_q) begin
            if (sec_cnt_q == 9'(SNOOZE_SECONDS - 1))
              state_d = RINGING;
            else
              sec_cnt_d = sec_cnt_q + 9'd1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    if (state_d != state_q) sec_cnt_d = '0;
`ifdef RING_SNOOZE_EN
    // A fresh event starts with no snoozes; IDLE holds none either.
    if (state_d == IDLE || state_q == IDLE) snz_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      match_q   <= 1'b0;
      stop_q    <= 1'b0;
      sec_p_q   <= 1'b0;
      match_p_q <= 1'b0;
      stop_p_q  <= 1'b0;
      state_q   <= IDLE;
      sec_cnt_q <= '0;
      buzzer_q  <= 1'b0;
      ringing_q <= 1'b0;
`ifdef RING_SNOOZE_EN
      snz_q      <= 1'b0;
      snz_p_q    <= 1'b0;
      snz_cnt_q  <= '0;
      snoozing_q <= 1'b0;
`endif
    end else begin
      tick_q    <= tick_1Hz;
      match_q   <= alarm_match;
      stop_q    <= stop_btn;
      sec_p_q   <= tick_1Hz & ~tick_q;
      match_p_q <= alarm_match & ~match_q;
      stop_p_q  <= stop_btn & ~stop_q;
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      ringing_q <= (state_d == RINGING);
      buzzer_q  <= (state_d == RINGING) & gate_4Hz & tone_500Hz;
`ifdef RING_SNOOZE_EN
      snz_q      <= snooze_btn;
      snz_p_q    <= snooze_btn & ~snz_q;
      snz_cnt_q  <= snz_cnt_d;
      snoozing_q <= (state_d == SNOOZE);
`endif
    end
  end

  assign buzzer_out = buzzer_q;
  assign ringing    = ringing_q;
`ifdef RING_SNOOZE_EN
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snz_cnt_q;
`else
  assign snoozing   = 1'b0;
  assign snooze_cnt = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl (ring=3 s, snooze=2 s, one snooze).
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tone, gate, tick;
  logic       en, match, stop, snz;
  logic       buz, rng, snzing;
  logic [2:0] scnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic g;
    logic t;
    logic exp;
  } vec_t;

  vec_t vecs[8];

  alarm_ring_ctrl #(
    .RING_SECONDS  (3),
    .SNOOZE_SECONDS(2),
    .MAX_SNOOZE    (1)
  ) dut (
    .clk_in_50M (clk),
    .rst_n      (rst_n),
    .tone_500Hz (tone),
    .gate_4Hz   (gate),
    .tick_1Hz   (tick),
    .alarm_en   (en),
    .alarm_match(match),
    .stop_btn   (stop),
    .snooze_btn (snz),
    .buzzer_out (buz),
    .ringing    (rng),
    .snoozing   (snzing),
    .snooze_cnt (scnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step(2);
    tick = 1'b0;
    step(2);
  endtask

  task automatic trig();
    match = 1'b1;
    step(2);
    match = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    tone = 1'b0; gate = 1'b0; tick = 1'b0;
    en = 1'b1; match = 1'b1; stop = 1'b0; snz = 1'b0;
    step(3);
    check("rst_ringing", rng, 0);
    check("rst_buzzer", buz, 0);
    check("rst_snoozing", snzing, 0);
    check("rst_snooze_cnt", scnt, 0);

    rst_n = 1'b1;
    step(1);
    check("release_c1_ringing", rng, 0);
    step(1);
    check("release_c2_ringing", rng, 1);
    match = 1'b0;

    for (int i = 0; i < 8; i++) begin
      gate = vecs[i].g;
      tone = vecs[i].t;
      step(1);
      check($sformatf("buzzer_vec%0d", i), buz, vecs[i].exp);
    end

    tick_once();
    check("to_t1_ringing", rng, 1);
    check("to_t1_buzzer", buz, 1);
    tick_once();
    check("to_t2_ringing", rng, 1);
    tick_once();
    check("to_t3_ringing", rng, 0);
    check("to_t3_buzzer", buz, 0);

    trig();
    check("stop_trig_ringing", rng, 1);
    tick_once();
    check("stop_sec_cnt1", dut.sec_cnt_q, 1);
    tick = 1'b1;
    stop = 1'b1;
    step(1);
    check("stop_c1_ringing", rng, 1);
    step(1);
    check("stop_c2_ringing", rng, 0);
    check("stop_sec_cnt", dut.sec_cnt_q, 0);
    tick = 1'b0;
    stop = 1'b0;
    step(2);

    trig();
    check("arst_trig_ringing", rng, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ringing", rng, 0);
    check("arst_buzzer", buz, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("arst_release_idle", rng, 0);

    trig();
    check("en_trig_ringing", rng, 1);
    en = 1'b0;
    step(1);
    check("en_drop_ringing", rng, 0);
    check("en_drop_buzzer", buz, 0);
    match = 1'b1;
    step(3);
    check("en_low_match_idle", rng, 0);
    match = 1'b0;
    en = 1'b1;
    step(2);

`ifdef RING_SNOOZE_EN
    trig();
    check("snz_trig_ringing", rng, 1);
    snz = 1'b1;
    step(2);
    snz = 1'b0;
    check("snz_snoozing", snzing, 1);
    check("snz_ringing", rng, 0);
    check("snz_cnt", scnt, 1);
    check("snz_buzzer", buz, 0);
    tick_once();
    check("snz_t1_snoozing", snzing, 1);
    tick_once();
    check("snz_t2_ringing", rng, 1);
    check("snz_t2_snoozing", snzing, 0);
    snz = 1'b1;
    step(2);
    snz = 1'b0;
    check("snz2_ignored_ringing", rng, 1);
    check("snz2_ignored_snoozing", snzing, 0);
    check("snz2_ignored_cnt", scnt, 1);
    tick_once();
    tick_once();
    check("snz_re_t2_ringing", rng, 1);
    tick_once();
    check("snz_re_t3_ringing", rng, 0);
    check("snz_idle_cnt", scnt, 0);

    trig();
    check("tie_trig_cnt", scnt, 0);
    tick_once();
    tick_once();
    tick = 1'b1;
    snz = 1'b1;
    step(2);
    tick = 1'b0;
    snz = 1'b0;
    check("tie_snz_timeout", snzing, 1);
    en = 1'b0;
    step(1);
    check("snz_en_drop_snoozing", snzing, 0);
    check("snz_en_drop_ringing", rng, 0);
    check("snz_en_drop_cnt", scnt, 0);
    en = 1'b1;
    step(2);

    trig();
    stop = 1'b1;
    snz = 1'b1;
    step(2);
    stop = 1'b0;
    snz = 1'b0;
    check("stop_snz_ringing", rng, 0);
    check("stop_snz_snoozing", snzing, 0);
    step(2);
`else
    trig();
    check("nosnz_trig_ringing", rng, 1);
    snz = 1'b1;
    step(2);
    snz = 1'b0;
    check("nosnz_ringing", rng, 1);
    check("nosnz_snoozing", snzing, 0);
    check("nosnz_cnt", scnt, 0);
    tick_once();
    snz = 1'b1;
    step(2);
    snz = 1'b0;
    tick_once();
    check("nosnz_t2_ringing", rng, 1);
    tick_once();
    check("nosnz_t3_ringing", rng, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
